// File: rtl/muldiv_hilo_if.sv
// Request/result bundle between the execute-stage controller and the HI/LO
// multiply/divide unit.
interface muldiv_hilo_if #(parameter int N = 32);
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (output start, op, a, b,
                    input  busy, done, div_by_zero, hi, lo);
    modport slave  (input  start, op, a, b,
                    output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_hilo.sv
// Multi-cycle signed/unsigned multiply and restoring divide owning HI/LO.
// Fixed N+1 cycle latency from accepted start to done; MTHI/MTLO write in one edge.
module muldiv_hilo #(
    parameter int N  = 32,
    parameter int CW = $clog2(N) + 1
) (
    input logic         clk,
    input logic         rst_n,
    muldiv_hilo_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] acc_q, acc_d;      // {upper, lower}: product, or {remainder, quotient}
    logic [N-1:0]   opnd_q, opnd_d;    // multiplicand / divisor magnitude
    logic [N-1:0]   a_raw_q, a_raw_d;
    logic           is_div_q, is_div_d;
    logic           neg_q, neg_d;
    logic           neg_rem_q, neg_rem_d;
    logic           divz_q, divz_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           done_q, done_d;
    logic           dbz_q, dbz_d;

    logic           a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic [N:0]     sum;
    logic [N:0]     trial;
    logic [2*N-1:0] prod;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        a_neg     = 1'b0;
        b_neg     = 1'b0;
        a_mag     = '0;
        b_mag     = '0;
        sum       = '0;
        trial     = '0;
        prod      = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    unique case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            // Even opcodes of the pair are the signed variants.
                            a_neg     = ~bus.op[0] & bus.a[N-1];
                            b_neg     = ~bus.op[0] & bus.b[N-1];
                            a_mag     = a_neg ? -bus.a : bus.a;
                            b_mag     = b_neg ? -bus.b : bus.b;
                            acc_d     = {{N{1'b0}}, a_mag};
                            opnd_d    = b_mag;
                            a_raw_d   = bus.a;
                            is_div_d  = bus.op[1];
                            neg_d     = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            divz_d    = (bus.b == '0);
                            cnt_d     = '0;
                            dbz_d     = 1'b0;
                            state_d   = RUN;
                        end
                        OP_MTHI: begin
                            hi_d   = bus.a;
                            done_d = 1'b1;
                            dbz_d  = 1'b0;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.a;
                            done_d = 1'b1;
                            dbz_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end

            RUN: begin
                if (is_div_q) begin
                    // Shift the next dividend bit into the partial remainder and try the subtract.
                    trial = acc_q[2*N-1:N-1] - {1'b0, opnd_q};
                    if (!trial[N]) acc_d = {trial[N-1:0], acc_q[N-2:0], 1'b1};
                    else           acc_d = {acc_q[2*N-2:N-1], acc_q[N-2:0], 1'b0};
                end else begin
                    sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
                    acc_d = {sum, acc_q[N-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N-1)) state_d = FIX;
            end

            FIX: begin
                if (is_div_q) begin
                    if (divz_q) begin
                        hi_d  = a_raw_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = neg_q     ? -acc_q[N-1:0]     : acc_q[N-1:0];
                        hi_d = neg_rem_q ? -acc_q[2*N-1:N]   : acc_q[2*N-1:N];
                    end
                end else begin
                    prod = neg_q ? -acc_q : acc_q;
                    hi_d = prod[2*N-1:N];
                    lo_d = prod[N-1:0];
                end
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule
